// File: rtl/pit_bus_master.sv
// Host-side bus initiator for an 8253-compatible interval timer: expands one
// program / latch-read command into a sequence of timer bus cycles.
module pit_bus_master #(
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned GAP_CYCLES    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_op,
    input  logic [1:0]  req_ctr,
    input  logic [2:0]  req_mode,
    input  logic [1:0]  req_rw,
    input  logic [15:0] req_value,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [15:0] resp_data,
    output logic        busy,
    output logic        pit_cs_n,
    output logic        pit_wr_n,
    output logic        pit_rd_n,
    output logic        pit_a1,
    output logic        pit_a0,
    output logic [7:0]  pit_d_o,
    output logic        pit_d_oe,
    input  logic [7:0]  pit_d_i
);

    // Handshake: a command transfers on a rising clk edge where req_valid and
    // req_ready are both high; req_ready is high only while the FSM is idle.

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_GAP, S_RESP
    } state_t;

    localparam logic [15:0] STB_LAST = 16'(STROBE_CYCLES - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic        op_q, op_d;
    logic [1:0]  ctr_q, ctr_d;
    logic [2:0]  mode_q, mode_d;
    logic [1:0]  rw_q, rw_d;
    logic [15:0] value_q, value_d;
    logic [7:0]  lsb_q, lsb_d;
    logic [7:0]  msb_q, msb_d;
    logic        ready_q, ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [15:0] resp_data_q, resp_data_d;
    logic        cs_n_q, cs_n_d;
    logic        wr_n_q, wr_n_d;
    logic        rd_n_q, rd_n_d;
    logic        a1_q, a1_d;
    logic        a0_q, a0_d;
    logic [7:0]  d_o_q, d_o_d;
    logic        d_oe_q, d_oe_d;

    logic        illegal;
    logic        last_cyc;
    logic [1:0]  nxt_idx;
    logic        is_wr;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        ctr_d        = ctr_q;
        mode_d       = mode_q;
        rw_d         = rw_q;
        value_d      = value_q;
        lsb_d        = lsb_q;
        msb_d        = msb_q;
        resp_err_d   = resp_err_q;
        resp_data_d  = resp_data_q;
        illegal      = (req_ctr == 2'd3) || (!req_op && (req_rw == 2'b00));
        last_cyc     = 1'b1;
        nxt_idx      = idx_q;

        // Sub-cycle index: 0 = control word, 1 = LSB transfer, 2 = MSB transfer.
        if (op_q) begin
            last_cyc = (idx_q == 2'd2);
            nxt_idx  = idx_q + 2'd1;
        end else begin
            case (idx_q)
                2'd0: begin
                    last_cyc = 1'b0;
                    nxt_idx  = rw_q[0] ? 2'd1 : 2'd2;
                end
                2'd1: begin
                    last_cyc = !rw_q[1];
                    nxt_idx  = 2'd2;
                end
                default: last_cyc = 1'b1;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    ctr_d   = req_ctr;
                    mode_d  = req_mode;
                    rw_d    = req_rw;
                    value_d = req_value;
                    idx_d   = 2'd0;
                    cnt_d   = 16'd0;
                    if (illegal) begin
                        state_d     = S_RESP;
                        resp_err_d  = 1'b1;
                        resp_data_d = 16'h0000;
                    end else begin
                        state_d = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                state_d = S_STROBE;
                cnt_d   = 16'd0;
            end
            S_STROBE: begin
                if (cnt_q == STB_LAST) begin
                    state_d = S_HOLD;
                    if (op_q && (idx_q == 2'd1)) lsb_d = pit_d_i;
                    if (op_q && (idx_q == 2'd2)) msb_d = pit_d_i;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_HOLD: begin
                state_d = S_GAP;
                cnt_d   = 16'd0;
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    if (last_cyc) begin
                        state_d     = S_RESP;
                        resp_err_d  = 1'b0;
                        resp_data_d = op_q ? {msb_q, lsb_q} : 16'h0000;
                    end else begin
                        state_d = S_SETUP;
                        idx_d   = nxt_idx;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        ready_d      = (state_d == S_IDLE);
        resp_valid_d = (state_d == S_RESP);

        // Bus pins are registered from the next state so they never glitch.
        cs_n_d = 1'b1;
        wr_n_d = 1'b1;
        rd_n_d = 1'b1;
        a1_d   = 1'b0;
        a0_d   = 1'b0;
        d_o_d  = 8'h00;
        d_oe_d = 1'b0;
        is_wr  = !op_d || (idx_d == 2'd0);
        if ((state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD)) begin
            cs_n_d       = 1'b0;
            {a1_d, a0_d} = (idx_d == 2'd0) ? 2'b11 : ctr_d;
            if (is_wr) begin
                d_oe_d = 1'b1;
                if (idx_d == 2'd0)      d_o_d = {ctr_d, (op_d ? 2'b00 : rw_d), mode_d, 1'b0};
                else if (idx_d == 2'd1) d_o_d = value_d[7:0];
                else                    d_o_d = value_d[15:8];
            end
            if (state_d == S_STROBE) begin
                wr_n_d = !is_wr;
                rd_n_d = is_wr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= 2'd0;
            cnt_q        <= 16'd0;
            op_q         <= 1'b0;
            ctr_q        <= 2'd0;
            mode_q       <= 3'd0;
            rw_q         <= 2'd0;
            value_q      <= 16'h0000;
            lsb_q        <= 8'h00;
            msb_q        <= 8'h00;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= 16'h0000;
            cs_n_q       <= 1'b1;
            wr_n_q       <= 1'b1;
            rd_n_q       <= 1'b1;
            a1_q         <= 1'b0;
            a0_q         <= 1'b0;
            d_o_q        <= 8'h00;
            d_oe_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            ctr_q        <= ctr_d;
            mode_q       <= mode_d;
            rw_q         <= rw_d;
            value_q      <= value_d;
            lsb_q        <= lsb_d;
            msb_q        <= msb_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_data_q  <= resp_data_d;
            cs_n_q       <= cs_n_d;
            wr_n_q       <= wr_n_d;
            rd_n_q       <= rd_n_d;
            a1_q         <= a1_d;
            a0_q         <= a0_d;
            d_o_q        <= d_o_d;
            d_oe_q       <= d_oe_d;
        end
    end

    assign req_ready  = ready_q;
    assign busy       = ~ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_data  = resp_data_q;
    assign pit_cs_n   = cs_n_q;
    assign pit_wr_n   = wr_n_q;
    assign pit_rd_n   = rd_n_q;
    assign pit_a1     = a1_q;
    assign pit_a0     = a0_q;
    assign pit_d_o    = d_o_q;
    assign pit_d_oe   = d_oe_q;

endmodule

// File: tb/tb_pit_bus_master.sv
// Bench for pit_bus_master: a bus monitor plus a small 8253 behavioural model,
// directed command steps and randomized commands checked against a reference.
module tb_pit_bus_master;

    localparam int S = 2;
    localparam int G = 2;

    logic        clk, rst_n;
    logic        req_valid, req_ready, req_op;
    logic [1:0]  req_ctr, req_rw;
    logic [2:0]  req_mode;
    logic [15:0] req_value;
    logic        resp_valid, resp_err, busy;
    logic [15:0] resp_data;
    logic        pit_cs_n, pit_wr_n, pit_rd_n, pit_a1, pit_a0, pit_d_oe;
    logic [7:0]  pit_d_o, pit_d_i;

    pit_bus_master #(.STROBE_CYCLES(S), .GAP_CYCLES(G)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_ctr(req_ctr), .req_mode(req_mode), .req_rw(req_rw), .req_value(req_value),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_data(resp_data), .busy(busy),
        .pit_cs_n(pit_cs_n), .pit_wr_n(pit_wr_n), .pit_rd_n(pit_rd_n),
        .pit_a1(pit_a1), .pit_a0(pit_a0), .pit_d_o(pit_d_o), .pit_d_oe(pit_d_oe),
        .pit_d_i(pit_d_i)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- bus monitor + timer model ----------------
    // Record format: {is_write, a1a0, write data (0 for reads)}
    logic [10:0] obs_q[$];
    int          stb_q[$], setup_q[$], hold_q[$], gap_q[$], bad_q[$];
    logic [7:0]  rd_q[$];
    int          idle_bad;
    bit          tmode;

    bit          in_cs;
    logic [1:0]  cur_addr;
    logic        cur_wr;
    logic [7:0]  cur_data, cur_do0;
    int          cur_stb, cur_setup, cur_hold, cur_gap, cur_bad, hi_cnt;
    bit          oe_lo, oe_hi;

    logic [15:0] t_count, t_reload, t_latch;
    logic [7:0]  t_lsb;
    logic [1:0]  t_rw;
    bit          t_wph, t_rd_ph, t_run;
    int          tdiv;

    initial begin
        pit_d_i = 8'h00; in_cs = 0; hi_cnt = 0; idle_bad = 0; tmode = 0;
        t_count = 0; t_reload = 0; t_latch = 0; t_lsb = 0; t_rw = 2'd3;
        t_wph = 0; t_rd_ph = 0; t_run = 0; tdiv = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_cs  = 0;
                hi_cnt = 0;
            end else begin
                tdiv++;
                if (tdiv == 5) begin
                    tdiv = 0;
                    if (t_run) t_count = (t_count <= 16'd1) ? t_reload : t_count - 16'd1;
                end
                if (!pit_cs_n) begin
                    if (!in_cs) begin
                        in_cs = 1; cur_addr = {pit_a1, pit_a0}; cur_wr = 0; cur_data = 8'h00;
                        cur_stb = 0; cur_setup = 0; cur_hold = 0; cur_bad = 0;
                        cur_gap = hi_cnt; cur_do0 = pit_d_o; oe_lo = 0; oe_hi = 0;
                    end
                    if ({pit_a1, pit_a0} !== cur_addr) cur_bad++;
                    if (pit_d_o !== cur_do0) cur_bad++;
                    if (pit_d_oe) oe_hi = 1; else oe_lo = 1;
                    if (!pit_wr_n || !pit_rd_n) begin
                        if (!pit_wr_n && !pit_rd_n) cur_bad++;
                        if (cur_stb == 0) begin
                            cur_wr = !pit_wr_n;
                            if (cur_wr) cur_data = pit_d_o;
                            else if (tmode && cur_addr == 2'd0) begin
                                pit_d_i = t_rd_ph ? t_latch[15:8] : t_latch[7:0];
                                t_rd_ph = !t_rd_ph;
                            end else begin
                                pit_d_i = (rd_q.size() > 0) ? rd_q.pop_front() : 8'h00;
                            end
                        end
                        cur_stb++;
                    end else if (cur_stb == 0) cur_setup++;
                    else cur_hold++;
                end else begin
                    if (in_cs) begin
                        in_cs = 0;
                        if (cur_wr ? oe_lo : oe_hi) cur_bad++;
                        obs_q.push_back({cur_wr, cur_addr, cur_data});
                        stb_q.push_back(cur_stb); setup_q.push_back(cur_setup);
                        hold_q.push_back(cur_hold); gap_q.push_back(cur_gap);
                        bad_q.push_back(cur_bad);
                        if (cur_wr && cur_addr == 2'd3 && cur_data[7:6] == 2'd0) begin
                            if (cur_data[5:4] == 2'd0) begin
                                t_latch = t_count; t_rd_ph = 0;
                            end else begin
                                t_rw = cur_data[5:4]; t_wph = (t_rw == 2'd2);
                            end
                        end else if (cur_wr && cur_addr == 2'd0) begin
                            if (!t_wph && t_rw == 2'd3) begin
                                t_lsb = cur_data; t_wph = 1;
                            end else begin
                                if (!t_wph) t_reload = {8'h00, cur_data};
                                else t_reload = {cur_data, (t_rw == 2'd3) ? t_lsb : 8'h00};
                                t_wph = (t_rw == 2'd2);
                                t_count = t_reload; t_run = 1;
                            end
                        end
                        hi_cnt = 0;
                    end
                    if ({pit_a1, pit_a0} != 2'b00 || pit_d_oe || !pit_wr_n || !pit_rd_n) idle_bad++;
                    hi_cnt++;
                end
            end
        end
    end

    // ---------------- reference model + driver ----------------
    logic [10:0] exp_q[$];

    task automatic run_cmd(input logic op, input logic [1:0] ctr, input logic [2:0] mode,
                           input logic [1:0] rw, input logic [15:0] value,
                           input logic [7:0] lsb_in, input logic [7:0] msb_in,
                           input logic chk_data, output logic [15:0] got);
        bit          legal;
        logic [7:0]  cw;
        logic [15:0] exp_data;
        int          lat, w, k, n;
        legal = (ctr != 2'd3) && (op || rw != 2'b00);
        cw = 8'(ctr * 64 + (op ? 0 : rw) * 16 + mode * 2);
        exp_q.delete();
        exp_data = 16'h0000;
        if (legal) begin
            exp_q.push_back({1'b1, 2'b11, cw});
            if (!op) begin
                if (rw[0]) exp_q.push_back({1'b1, ctr, value[7:0]});
                if (rw[1]) exp_q.push_back({1'b1, ctr, value[15:8]});
            end else begin
                exp_q.push_back({1'b0, ctr, 8'h00});
                exp_q.push_back({1'b0, ctr, 8'h00});
                exp_data = {msb_in, lsb_in};
            end
        end
        lat = exp_q.size() * (2 + S + G);
        rd_q.delete();
        rd_q.push_back(lsb_in);
        rd_q.push_back(msb_in);
        obs_q.delete(); stb_q.delete(); setup_q.delete(); hold_q.delete();
        gap_q.delete(); bad_q.delete(); idle_bad = 0;

        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_ctr = ctr; req_mode = mode; req_rw = rw; req_value = value;
        w = 0;
        while (!req_ready && w < 100) begin @(negedge clk); w++; end
        check("accept_ready", req_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_op = 1'($urandom); req_ctr = 2'($urandom); req_mode = 3'($urandom);
        req_rw = 2'($urandom); req_value = 16'($urandom);
        k = 0;
        while (!resp_valid && k < 300) begin @(negedge clk); k++; end
        check("resp_latency", k, lat);
        check("resp_err", resp_err, !legal);
        if (chk_data) check("resp_data", resp_data, exp_data);
        check("busy_in_resp", busy, 1'b1);
        got = resp_data;
        @(negedge clk);
        check("resp_pulse_end", resp_valid, 1'b0);
        check("ready_after_resp", req_ready, 1'b1);
        check("resp_data_held", resp_data, got);
        check("bus_cycle_count", obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("bus_rec%0d", i), obs_q[i], exp_q[i]);
            check($sformatf("strobe_len%0d", i), stb_q[i], S);
            check($sformatf("setup_len%0d", i), setup_q[i], 1);
            check($sformatf("hold_len%0d", i), hold_q[i], 1);
            check($sformatf("stable%0d", i), bad_q[i], 0);
            if (i > 0) check($sformatf("gap_len%0d", i), gap_q[i], G);
        end
        check("idle_bus_quiet", idle_bad, 0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [15:0] got, r1, r2;
        int          w;
        logic        op;
        logic [1:0]  ctr, rw;
        rst_n = 1'b0; req_valid = 1'b0; req_op = 1'b0; req_ctr = 2'd0;
        req_mode = 3'd0; req_rw = 2'd0; req_value = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_err", resp_err, 1'b0);
        check("rst_resp_data", resp_data, 16'h0000);
        check("rst_strobes", {pit_cs_n, pit_wr_n, pit_rd_n}, 3'b111);
        check("rst_addr", {pit_a1, pit_a0}, 2'b00);
        check("rst_d_o", pit_d_o, 8'h00);
        check("rst_d_oe", pit_d_oe, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Program ctr0 mode 3 rw=11 value 0x1234
        run_cmd(1'b0, 2'd0, 3'd3, 2'b11, 16'h1234, 8'h00, 8'h00, 1'b1, got);
        if (obs_q.size() == 3) begin
            check("prog1_cw", obs_q[0][7:0], 8'h36);
            check("prog1_lsb", obs_q[1][7:0], 8'h34);
            check("prog1_msb", obs_q[2][7:0], 8'h12);
        end
        // Program ctr2 mode 2 rw=01 value 0x00AB
        run_cmd(1'b0, 2'd2, 3'd2, 2'b01, 16'h00AB, 8'h00, 8'h00, 1'b1, got);
        if (obs_q.size() == 2) check("prog2_cw", obs_q[0], {1'b1, 2'b11, 8'h94});
        // Latch-read ctr1, bus returns 0xCD then 0xAB
        run_cmd(1'b1, 2'd1, 3'd0, 2'b00, 16'h0000, 8'hCD, 8'hAB, 1'b1, got);
        check("latch_read_data", got, 16'hABCD);
        if (obs_q.size() == 3) check("latch_cw", obs_q[0][7:0], 8'h40);
        // Illegal commands
        run_cmd(1'b0, 2'd3, 3'd1, 2'b11, 16'h5555, 8'h00, 8'h00, 1'b1, got);
        run_cmd(1'b1, 2'd3, 3'd0, 2'b00, 16'h0000, 8'h11, 8'h22, 1'b1, got);
        run_cmd(1'b0, 2'd1, 3'd0, 2'b00, 16'h7777, 8'h00, 8'h00, 1'b1, got);

        // Reset during the MSB write strobe
        obs_q.delete(); stb_q.delete(); setup_q.delete(); hold_q.delete();
        gap_q.delete(); bad_q.delete();
        @(negedge clk);
        req_valid = 1'b1; req_op = 1'b0; req_ctr = 2'd1; req_mode = 3'd2;
        req_rw = 2'b11; req_value = 16'hBEEF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        w = 0;
        #1;
        while (!(obs_q.size() == 2 && !pit_wr_n) && w < 200) begin @(negedge clk); #1; w++; end
        check("reached_msb_strobe", (obs_q.size() == 2) && !pit_wr_n, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_wr_n", pit_wr_n, 1'b1);
        check("async_rst_cs_n", pit_cs_n, 1'b1);
        check("async_rst_d_oe", pit_d_oe, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check("no_resp_after_rst", resp_valid, 1'b0);
        end
        check("ready_after_rst", req_ready, 1'b1);
        run_cmd(1'b0, 2'd1, 3'd2, 2'b11, 16'hBEEF, 8'h00, 8'h00, 1'b1, got);

        // Randomized commands against the reference model
        for (int i = 0; i < 25; i++) begin
            op  = 1'($urandom_range(0, 1));
            ctr = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            rw  = 2'($urandom_range(0, 3));
            run_cmd(op, ctr, 3'($urandom_range(0, 5)), rw, 16'($urandom),
                    8'($urandom), 8'($urandom), 1'b1, got);
        end

        // Closed loop with the timer model
        tmode = 1;
        run_cmd(1'b0, 2'd0, 3'd2, 2'b11, 16'd4, 8'h00, 8'h00, 1'b1, got);
        run_cmd(1'b1, 2'd0, 3'd2, 2'b00, 16'h0000, 8'h00, 8'h00, 1'b0, r1);
        run_cmd(1'b1, 2'd0, 3'd2, 2'b00, 16'h0000, 8'h00, 8'h00, 1'b0, r2);
        check("loop_r1_nonzero", r1 != 16'd0, 1'b1);
        check("loop_r1_le4", r1 <= 16'd4, 1'b1);
        check("loop_r2_nonzero", r2 != 16'd0, 1'b1);
        check("loop_r2_le4", r2 <= 16'd4, 1'b1);
        check("loop_non_increasing", (r2 <= r1) || (r2 == 16'd4), 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
